// File: rtl/blood_splat_renderer.sv
// Animated blood-splat compositor over a VGA pixel stream.
// Drives 64x64 frame ROM addresses and keys transparent texels to background.
module blood_splat_renderer #(
   parameter int          NUM_FRAMES = 4,
   parameter int          FRAME_HOLD = 6,
   parameter logic [11:0] KEY_COLOR  = 12'h000,
   parameter int          FW         = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hit_trig,
   input  logic [9:0]    hit_x,
   input  logic [9:0]    hit_y,
   input  logic          frame_tick,
   input  logic          video_on,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic [11:0]   bg_rgb,
   output logic [5:0]    rom_row,
   output logic [5:0]    rom_col,
   output logic [FW-1:0] rom_frame,
   input  logic [11:0]   rom_data,
   output logic [11:0]   rgb_out,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          busy,
   output logic          done
);

   localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;

   state_t        state_q, state_d;
   logic [FW-1:0] frame_q;
   logic [HW-1:0] hold_q;
   logic [9:0]    pos_x_q, pos_y_q;
   logic [9:0]    pend_x_q, pend_y_q;
   logic          busy_q, done_q;

   logic          adv, last_hold, last_frame, fin;
   logic [9:0]    dx, dy;
   logic          in_box;

   logic          in_box_q, von_q, hs_q, vs_q;
   logic [11:0]   bg_q;
   logic [11:0]   rgb_q;
   logic          hs2_q, vs2_q;

   // Retrigger has priority over any frame advance in the same cycle.
   assign adv        = (state_q == PLAY) && frame_tick && !hit_trig;
   assign last_hold  = (hold_q == HW'(FRAME_HOLD - 1));
   assign last_frame = (frame_q == FW'(NUM_FRAMES - 1));
   assign fin        = adv && last_hold && last_frame;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (hit_trig) state_d = ARM;
         ARM: begin
            if (!hit_trig && frame_tick) state_d = PLAY;
         end
         PLAY: begin
            if (hit_trig) state_d = ARM;
            else if (fin) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         hold_q   <= '0;
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         pend_x_q <= '0;
         pend_y_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= fin;
         if (hit_trig) begin
            pend_x_q <= hit_x;
            pend_y_q <= hit_y;
         end
         if (state_q == ARM && !hit_trig && frame_tick) begin
            pos_x_q <= pend_x_q;
            pos_y_q <= pend_y_q;
            frame_q <= '0;
            hold_q  <= '0;
         end
         if (adv) begin
            if (last_hold) begin
               hold_q <= '0;
               if (!last_frame) frame_q <= frame_q + FW'(1);
            end else begin
               hold_q <= hold_q + HW'(1);
            end
         end
      end
   end

   // Pixels left of / above the splat wrap to large offsets and fall out.
   assign dx     = pixel_x - pos_x_q;
   assign dy     = pixel_y - pos_y_q;
   assign in_box = (state_q == PLAY) && (dx[9:6] == 4'd0)
                   && (dy[9:6] == 4'd0);

   assign rom_row   = dy[5:0];
   assign rom_col   = dx[5:0];
   assign rom_frame = frame_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_box_q <= 1'b0;
         von_q    <= 1'b0;
         bg_q     <= '0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         rgb_q    <= '0;
         hs2_q    <= 1'b0;
         vs2_q    <= 1'b0;
      end else begin
         in_box_q <= in_box;
         von_q    <= video_on;
         bg_q     <= bg_rgb;
         hs_q     <= hsync_in;
         vs_q     <= vsync_in;
         hs2_q    <= hs_q;
         vs2_q    <= vs_q;
         if (!von_q)
            rgb_q <= '0;
         else if (in_box_q && rom_data != KEY_COLOR)
            rgb_q <= rom_data;
         else
            rgb_q <= bg_q;
      end
   end

   assign rgb_out   = rgb_q;
   assign hsync_out = hs2_q;
   assign vsync_out = vs2_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_blood_splat_renderer.sv
// Randomised and directed checks of blood_splat_renderer against a
// tick-counting animation model and a two-deep pixel pipeline model.
module tb_blood_splat_renderer;

   localparam int NF   = 4;
   localparam int HOLD = 6;
   localparam logic [11:0] KEY = 12'h000;

   logic        clk = 0;
   logic        rst_n;
   logic        hit_trig, frame_tick, video_on, hsync_in, vsync_in;
   logic [9:0]  hit_x, hit_y, pixel_x, pixel_y;
   logic [11:0] bg_rgb, rom_data, rgb_out;
   logic [5:0]  rom_row, rom_col;
   logic [1:0]  rom_frame;
   logic        hsync_out, vsync_out, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   blood_splat_renderer #(
      .NUM_FRAMES(NF), .FRAME_HOLD(HOLD), .KEY_COLOR(KEY), .FW(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .hit_trig(hit_trig), .hit_x(hit_x), .hit_y(hit_y),
      .frame_tick(frame_tick), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb),
      .rom_row(rom_row), .rom_col(rom_col), .rom_frame(rom_frame),
      .rom_data(rom_data), .rgb_out(rgb_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .busy(busy), .done(done)
   );

   function automatic logic [11:0] rom_f(int f, int r, int c);
      if (f == 0 && r == 3 && c == 5) return 12'hE00;
      if (((r * 7 + c * 3 + f) % 5) == 0) return 12'h000;
      return 12'((f * 419 + r * 67 + c * 13 + 1) & 12'hFFF);
   endfunction

   // Synchronous frame ROM: data one clock after address.
   initial rom_data = '0;
   always @(posedge clk)
      rom_data <= rom_f(int'(rom_frame), int'(rom_row), int'(rom_col));

   // Model: 0 idle, 1 armed, 2 playing; ticks counted since play start.
   int          m_st, m_ticks, m_frame;
   logic [9:0]  m_px, m_py, m_ex, m_ey;
   logic [11:0] p1_rgb, e_rgb;
   logic        p1_hs, p1_vs, e_hs, e_vs, e_done;

   task automatic m_reset();
      m_st = 0; m_ticks = 0; m_frame = 0;
      m_px = 0; m_py = 0; m_ex = 0; m_ey = 0;
      p1_rgb = 0; e_rgb = 0;
      p1_hs = 0; p1_vs = 0; e_hs = 0; e_vs = 0; e_done = 0;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      logic [9:0]  dx, dy;
      logic        ib, h, t, von, hs, vs;
      logic [11:0] rv, cur;
      logic [9:0]  hx, hy;
      #1;
      dx = pixel_x - m_px;
      dy = pixel_y - m_py;
      chk("rom_row", 32'(rom_row), 32'(dy[5:0]));
      chk("rom_col", 32'(rom_col), 32'(dx[5:0]));
      chk("rom_frame", 32'(rom_frame), 32'(m_frame));
      ib  = (m_st == 2) && (dx < 64) && (dy < 64);
      rv  = rom_f(m_frame, int'(dy[5:0]), int'(dx[5:0]));
      cur = !video_on ? 12'h000 : (ib && rv != KEY) ? rv : bg_rgb;
      h = hit_trig; t = frame_tick; hx = hit_x; hy = hit_y;
      von = video_on; hs = hsync_in; vs = vsync_in;
      @(posedge clk);
      if (!rst_n) begin
         m_reset();
      end else begin
         e_rgb = p1_rgb; p1_rgb = cur;
         e_hs = p1_hs; p1_hs = hs;
         e_vs = p1_vs; p1_vs = vs;
         e_done = 0;
         if (h) begin
            m_ex = hx; m_ey = hy; m_st = 1;
         end else if (m_st == 1 && t) begin
            m_px = m_ex; m_py = m_ey;
            m_ticks = 0; m_frame = 0; m_st = 2;
         end else if (m_st == 2 && t) begin
            m_ticks++;
            if (m_ticks == HOLD * NF) begin
               m_st = 0; e_done = 1;
            end else begin
               m_frame = m_ticks / HOLD;
            end
         end
      end
      @(negedge clk);
      chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
      chk("hsync_out", 32'(hsync_out), 32'(e_hs));
      chk("vsync_out", 32'(vsync_out), 32'(e_vs));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("done", 32'(done), 32'(e_done));
      if (von && 0) $display("unused");
   endtask

   task automatic pix(int x, int y, logic von, logic [11:0] bg);
      pixel_x = 10'(x); pixel_y = 10'(y);
      video_on = von; bg_rgb = bg;
   endtask

   task automatic tick();
      frame_tick = 1; step(); frame_tick = 0; step();
   endtask

   int done_at;
   int bx, by;

   initial begin
      rst_n = 0; hit_trig = 0; frame_tick = 0;
      hit_x = 0; hit_y = 0; hsync_in = 0; vsync_in = 0;
      pix(0, 0, 0, 12'h000);
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_rgb", 32'(rgb_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_frame", 32'(rom_frame), 32'h0);
      rst_n = 1;
      step();

      // Single hit at (100,50).
      hit_trig = 1; hit_x = 100; hit_y = 50;
      step();
      hit_trig = 0;
      chk("busy_after_hit", 32'(busy), 32'h1);
      pix(105, 53, 1, 12'h0F0);
      step();
      frame_tick = 1; step(); frame_tick = 0;
      pix(105, 53, 1, 12'h0F0);
      #1;
      chk("row_lit", 32'(rom_row), 32'd3);
      chk("col_lit", 32'(rom_col), 32'd5);
      step();
      pix(99, 53, 1, 12'hABC);
      step();
      chk("rgb_splat_lit", 32'(rgb_out), 32'hE00);
      pix(164, 53, 1, 12'h123);
      step();
      chk("rgb_left_lit", 32'(rgb_out), 32'hABC);
      pix(100, 50, 1, 12'h456);
      step();
      chk("rgb_right_lit", 32'(rgb_out), 32'h123);
      pix(105, 53, 0, 12'h789);
      step();
      chk("rgb_key_lit", 32'(rgb_out), 32'h456);
      pix(0, 0, 0, 12'h000);
      step();
      chk("rgb_blank_lit", 32'(rgb_out), 32'h000);

      // Run the animation to completion.
      done_at = 0;
      for (int i = 1; i <= 30 && done_at == 0; i++) begin
         frame_tick = 1; step(); frame_tick = 0;
         if (done) done_at = i;
         step();
      end
      chk("done_tick", 32'(done_at), 32'd24);
      chk("idle_after", 32'(busy), 32'h0);

      // Retrigger during frame 2 with a simultaneous frame tick.
      hit_trig = 1; hit_x = 100; hit_y = 50; step(); hit_trig = 0;
      tick();
      repeat (12) tick();
      hit_trig = 1; frame_tick = 1; hit_x = 300; hit_y = 200;
      step();
      hit_trig = 0; frame_tick = 0;
      chk("retrig_done", 32'(done), 32'h0);
      chk("retrig_frame", 32'(rom_frame), 32'd2);
      chk("retrig_busy", 32'(busy), 32'h1);
      pix(301, 201, 1, 12'h321);
      repeat (3) step();
      tick();
      chk("new_frame", 32'(rom_frame), 32'd0);
      pix(301, 201, 1, 12'h321);
      #1;
      chk("new_pos_row", 32'(rom_row), 32'd1);
      step();

      // Asynchronous reset mid-play.
      rst_n = 0;
      #1;
      chk("arst_rgb", 32'(rgb_out), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_frame", 32'(rom_frame), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      m_reset();
      step();
      rst_n = 1;
      step();

      // Hit in idle during active video: position holds until a tick.
      hit_trig = 1; hit_x = 400; hit_y = 300;
      pix(405, 305, 1, 12'h111);
      step();
      hit_trig = 0;
      #1;
      chk("pos_held", 32'(rom_col), 32'd21);
      repeat (3) step();

      // Randomised traffic.
      bx = 400; by = 300;
      for (int i = 0; i < 3000; i++) begin
         hit_trig   = ($urandom_range(0, 299) == 0);
         frame_tick = ($urandom_range(0, 15) == 0);
         if (hit_trig) begin
            bx = $urandom_range(0, 600);
            by = $urandom_range(0, 450);
            hit_x = 10'(bx); hit_y = 10'(by);
         end
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
         pix(bx + $urandom_range(0, 90) - 10,
             by + $urandom_range(0, 90) - 10,
             ($urandom_range(0, 4) != 0), 12'($urandom));
         step();
      end
      hit_trig = 0; frame_tick = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
